alu_bitserial_seq: RTL and testbench

Bit-serial ALU sequencer: latches two WIDTH-bit operands and an opcode, then drives a combinational 1-bit ALU slice once per clock, LSB first, feeding each bit's carry/borrow back as the next bit's carry-in. It assembles the WIDTH-bit result and the final carry/borrow, then pulses `done`. It sits directly upstream of the 1-bit slice, which is its only consumer, and turns that slice into a multi-bit datapath for the control logic above it.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_bit_slice.sv | 35 +++
 rtl/alu_bitserial_seq.sv | 116 +++++++++++
 tb/tb_alu_bitserial_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state type for the bit-serial ALU.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: AND/OR, full add, and full subtract with borrow out.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       A,
    input  logic       B,
    input  logic       Cin,
    input  logic [1:0] sel,
    output logic       Result,
    output logic       Cout
);

    logic [1:0] w_sum;
    logic [1:0] w_diff;

    // Two-bit arithmetic so the upper bit is the carry (add) or borrow (subtract).
    assign w_sum  = {1'b0, A} + {1'b0, B} + {1'b0, Cin};
    assign w_diff = {1'b0, A} - {1'b0, B} - {1'b0, Cin};

    always_comb begin
        Result = 1'b0;
        Cout   = 1'b0;
        case (sel)
            OP_AND: Result = A & B;
            OP_OR:  Result = A | B;
            OP_ADD: {Cout, Result} = w_sum;
            OP_SUB: {Cout, Result} = w_diff;
            default: begin
                Result = 1'b0;
                Cout   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: feeds one operand bit pair per clock through the slice,
// LSB first, chaining carry/borrow, then publishes result, carry_out and zero.
module alu_bitserial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out,
    output logic             o_zero
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_aShift;
    logic [WIDTH-1:0] r_bShift;
    logic [WIDTH-1:0] r_resShift;
    logic             r_carry;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_carryOut;
    logic             r_zero;

    logic             w_sliceRes;
    logic             w_sliceCout;
    logic             w_accept;
    logic             w_running;
    logic             w_lastBit;
    logic [WIDTH-1:0] w_resNext;

    alu_bit_slice u_slice (
        .A      (r_aShift[0]),
        .B      (r_bShift[0]),
        .Cin    (r_carry),
        .sel    (r_op),
        .Result (w_sliceRes),
        .Cout   (w_sliceCout)
    );

    // A new request is taken in IDLE and in DONE, which gives back-to-back issue.
    assign w_accept  = i_start && (r_state != RUN);
    assign w_running = (r_state == RUN);
    assign w_lastBit = w_running && (r_cnt == LAST);
    assign w_resNext = {w_sliceRes, r_resShift[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? RUN : IDLE;
            RUN:     w_next = (r_cnt == LAST) ? DONE : RUN;
            DONE:    w_next = i_start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Published outputs move only on the final bit, so they hold through the next run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_aShift   <= '0;
            r_bShift   <= '0;
            r_resShift <= '0;
            r_carry    <= 1'b0;
            r_op       <= OP_AND;
            r_result   <= '0;
            r_carryOut <= 1'b0;
            r_zero     <= 1'b1;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_aShift <= i_a;
            r_bShift <= i_b;
            r_carry  <= i_cin;
            r_op     <= i_op;
        end else if (w_running) begin
            r_aShift   <= r_aShift >> 1;
            r_bShift   <= r_bShift >> 1;
            r_resShift <= w_resNext;
            r_carry    <= w_sliceCout;
            if (w_lastBit) begin
                r_result   <= w_resNext;
                r_carryOut <= w_sliceCout;
                r_zero     <= (w_resNext == '0);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_busy      = (r_state == RUN);
    assign o_done      = (r_state == DONE);
    assign o_result    = r_result;
    assign o_carry_out = r_carryOut;
    assign o_zero      = r_zero;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Directed self-checking bench for alu_bitserial_seq with hand-computed expectations.
module tb_alu_bitserial_seq;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryOut;
    logic             zero;

    int total = 0;
    int bad   = 0;

    alu_bitserial_seq #(.WIDTH(WIDTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_op        (op),
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_carry_out (carryOut),
        .o_zero      (zero)
    );

    always #5 clk = ~clk;

    // Presents one request on a falling edge; returns just after the accepting edge.
    task automatic launch(input logic [1:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic c);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        cin   = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        op    = ~o;
        cin   = ~c;
    endtask

    task automatic runOp(input logic [1:0] o, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic c);
        launch(o, x, y, c);
        repeat (WIDTH + 1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = OP_AND;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        total++; if (result !== 8'h00) begin bad++; $display("[TB] FAIL reset_result: got %h expected 00", result); end
        total++; if (carryOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_carry: got %b expected 0", carryOut); end
        total++; if (zero !== 1'b1) begin bad++; $display("[TB] FAIL reset_zero: got %b expected 1", zero); end
        rst = 1'b0;
    endtask

    task automatic test_add_basic();
        int busyCnt = 0;
        int doneCnt = 0;
        launch(OP_ADD, 8'h7F, 8'h01, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) doneCnt++;
        end
        @(negedge clk);
        total++; if (busyCnt != WIDTH) begin bad++; $display("[TB] FAIL add_busy_cycles: got %0d expected %0d", busyCnt, WIDTH); end
        total++; if (doneCnt != 0) begin bad++; $display("[TB] FAIL add_early_done: got %0d expected 0", doneCnt); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL add_done: got %b expected 1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL add_busy_in_done: got %b expected 0", busy); end
        total++; if (result !== 8'h80) begin bad++; $display("[TB] FAIL add_result: got %h expected 80", result); end
        total++; if (carryOut !== 1'b0) begin bad++; $display("[TB] FAIL add_carry: got %b expected 0", carryOut); end
        total++; if (zero !== 1'b0) begin bad++; $display("[TB] FAIL add_zero: got %b expected 0", zero); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL add_done_width: got %b expected 0", done); end
        total++; if (result !== 8'h80) begin bad++; $display("[TB] FAIL add_result_hold: got %h expected 80", result); end
    endtask

    task automatic test_add_carry();
        runOp(OP_ADD, 8'hFF, 8'h01, 1'b0);
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL addc_done: got %b expected 1", done); end
        total++; if (result !== 8'h00) begin bad++; $display("[TB] FAIL addc_result: got %h expected 00", result); end
        total++; if (carryOut !== 1'b1) begin bad++; $display("[TB] FAIL addc_carry: got %b expected 1", carryOut); end
        total++; if (zero !== 1'b1) begin bad++; $display("[TB] FAIL addc_zero: got %b expected 1", zero); end
    endtask

    task automatic test_sub();
        runOp(OP_SUB, 8'h05, 8'h07, 1'b0);
        total++; if (result !== 8'hFE) begin bad++; $display("[TB] FAIL sub1_result: got %h expected fe", result); end
        total++; if (carryOut !== 1'b1) begin bad++; $display("[TB] FAIL sub1_borrow: got %b expected 1", carryOut); end
        total++; if (zero !== 1'b0) begin bad++; $display("[TB] FAIL sub1_zero: got %b expected 0", zero); end
        runOp(OP_SUB, 8'h09, 8'h04, 1'b1);
        total++; if (result !== 8'h04) begin bad++; $display("[TB] FAIL sub2_result: got %h expected 04", result); end
        total++; if (carryOut !== 1'b0) begin bad++; $display("[TB] FAIL sub2_borrow: got %b expected 0", carryOut); end
    endtask

    task automatic test_back_to_back();
        runOp(OP_AND, 8'hF0, 8'h3C, 1'b1);
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL and_done: got %b expected 1", done); end
        total++; if (result !== 8'h30) begin bad++; $display("[TB] FAIL and_result: got %h expected 30", result); end
        total++; if (carryOut !== 1'b0) begin bad++; $display("[TB] FAIL and_carry: got %b expected 0", carryOut); end
        start = 1'b1;
        op    = OP_OR;
        a     = 8'hF0;
        b     = 8'h3C;
        cin   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_no_bubble: got busy=%b expected 1", busy); end
        total++; if (result !== 8'h30) begin bad++; $display("[TB] FAIL b2b_result_hold: got %h expected 30", result); end
        repeat (WIDTH + 1) @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL or_done: got %b expected 1", done); end
        total++; if (result !== 8'hFC) begin bad++; $display("[TB] FAIL or_result: got %h expected fc", result); end
        total++; if (carryOut !== 1'b0) begin bad++; $display("[TB] FAIL or_carry: got %b expected 0", carryOut); end
    endtask

    task automatic test_protocol();
        int            doneCnt = 0;
        logic [WIDTH-1:0] seen = '0;
        logic          seenCarry = 1'b1;
        launch(OP_ADD, 8'h12, 8'h34, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) begin
            @(negedge clk);
            if (done === 1'b1) doneCnt++;
            start = (i % 2 == 0);
            a     = 8'(i * 37);
            op    = 2'(i);
            cin   = 1'(i);
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                doneCnt++;
                seen      = result;
                seenCarry = carryOut;
            end
        end
        total++; if (doneCnt != 1) begin bad++; $display("[TB] FAIL proto_done_count: got %0d expected 1", doneCnt); end
        total++; if (seen !== 8'h46) begin bad++; $display("[TB] FAIL proto_result: got %h expected 46", seen); end
        total++; if (seenCarry !== 1'b0) begin bad++; $display("[TB] FAIL proto_carry: got %b expected 0", seenCarry); end
    endtask

    task automatic test_reset_mid_run();
        int doneCnt = 0;
        launch(OP_ADD, 8'h33, 8'h44, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
        total++; if (result !== 8'h00) begin bad++; $display("[TB] FAIL abort_result: got %h expected 00", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("[TB] FAIL abort_zero: got %b expected 1", zero); end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) doneCnt++;
        end
        total++; if (doneCnt != 0) begin bad++; $display("[TB] FAIL abort_activity: got %0d expected 0", doneCnt); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_back_to_back();
        test_protocol();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
